// File: rtl/abcd_vec_seq.sv
// Stimulus sequencer for the qc block: walks an ascending 4-bit code across A..D,
// holding each code for HOLD_CYCLES unpaused cycles, with start/abort/pause control.
module abcd_vec_seq #(
    parameter int HOLD_CYCLES = 10,
    parameter int LAST_CODE   = 4,
    parameter int CONTINUOUS  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       vec_valid,
    output logic       vec_strobe,
    output logic [3:0] vec_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] CODE_LAST = 4'(LAST_CODE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;
    logic [7:0] hold_q, hold_d;
    logic       new_code;

    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] out_q, out_d;

    // State register: sequencing state and every output are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            code_q   <= 4'd0;
            hold_q   <= 8'd0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    // Next-state: end-of-sequence is decided before incrementing, so code never overflows.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        hold_d   = hold_q;
        new_code = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_DRIVE;
                    code_d   = 4'd0;
                    hold_d   = 8'd0;
                    new_code = 1'b1;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    code_d  = 4'd0;
                    hold_d  = 8'd0;
                end else if (!pause) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = 8'd0;
                        if (code_q != CODE_LAST) begin
                            code_d   = code_q + 4'd1;
                            new_code = 1'b1;
                        end else if (CONTINUOUS != 0) begin
                            code_d   = 4'd0;
                            new_code = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                code_d  = 4'd0;
                hold_d  = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                code_d  = 4'd0;
                hold_d  = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        valid_d  = (state_d == S_DRIVE);
        busy_d   = (state_d == S_DRIVE);
        strobe_d = new_code;
        done_d   = (state_d == S_DONE);
        out_d    = (state_d == S_DRIVE) ? code_d : 4'd0;
    end

    assign A          = out_q[3];
    assign B          = out_q[2];
    assign C          = out_q[1];
    assign D          = out_q[0];
    assign vec_idx    = out_q;
    assign vec_valid  = valid_q;
    assign vec_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_abcd_vec_seq.sv
// Directed bench for abcd_vec_seq: three parameterisations share the control inputs;
// each scenario checks the instance it targets against hand-derived cycle tables.
module tb_abcd_vec_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic pause = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic a0, b0, c0, d0, val0, stb0, busy0, done0;
    logic a1, b1, c1, d1, val1, stb1, busy1, done1;
    logic a2, b2, c2, d2, val2, stb2, busy2, done2;
    logic [3:0] idx0, idx1, idx2;

    abcd_vec_seq #(.HOLD_CYCLES(10), .LAST_CODE(4), .CONTINUOUS(0)) u_def (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .A(a0), .B(b0), .C(c0), .D(d0), .vec_valid(val0), .vec_strobe(stb0),
        .vec_idx(idx0), .busy(busy0), .done(done0)
    );

    abcd_vec_seq #(.HOLD_CYCLES(1), .LAST_CODE(15), .CONTINUOUS(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .A(a1), .B(b1), .C(c1), .D(d1), .vec_valid(val1), .vec_strobe(stb1),
        .vec_idx(idx1), .busy(busy1), .done(done1)
    );

    abcd_vec_seq #(.HOLD_CYCLES(2), .LAST_CODE(1), .CONTINUOUS(1)) u_cont (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .A(a2), .B(b2), .C(c2), .D(d2), .vec_valid(val2), .vec_strobe(stb2),
        .vec_idx(idx2), .busy(busy2), .done(done2)
    );

    // Observation word: {valid, strobe, busy, done, A,B,C,D, vec_idx}
    wire [11:0] obs_def  = {val0, stb0, busy0, done0, a0, b0, c0, d0, idx0};
    wire [11:0] obs_fast = {val1, stb1, busy1, done1, a1, b1, c1, d1, idx1};
    wire [11:0] obs_cont = {val2, stb2, busy2, done2, a2, b2, c2, d2, idx2};

    localparam logic [11:0] EXP_IDLE = 12'h000;
    localparam logic [11:0] EXP_DONE = 12'h100;

    function automatic logic [11:0] drv(input int code, input logic stb);
        logic [3:0] c;
        c = 4'(code);
        return {1'b1, stb, 1'b1, 1'b0, c, c};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_pulse;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (obs_def !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL reset_def: got %h expected %h", obs_def, EXP_IDLE);
        end
        n_checks++;
        if (obs_fast !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL reset_fast: got %h expected %h", obs_fast, EXP_IDLE);
        end
        n_checks++;
        if (obs_cont !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL reset_cont: got %h expected %h", obs_cont, EXP_IDLE);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs_def !== EXP_IDLE) begin
                n_fail++;
                $display("FAIL idle_no_start cyc %0d: got %h expected %h", i, obs_def, EXP_IDLE);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_default;
        logic [11:0] exp;
        do_reset();
        start_pulse();
        for (int cyc = 1; cyc <= 53; cyc++) begin
            if (cyc <= 50)      exp = drv((cyc - 1) / 10, ((cyc - 1) % 10) == 0);
            else if (cyc == 51) exp = EXP_DONE;
            else                exp = EXP_IDLE;
            n_checks++;
            if (obs_def !== exp) begin
                n_fail++;
                $display("FAIL default cyc %0d: got %h expected %h", cyc, obs_def, exp);
            end
            tick();
        end
        $display("test_default done");
    endtask

    task automatic test_hold1_last15;
        logic [11:0] exp;
        do_reset();
        start_pulse();
        for (int cyc = 1; cyc <= 18; cyc++) begin
            if (cyc <= 16)      exp = drv(cyc - 1, 1'b1);
            else if (cyc == 17) exp = EXP_DONE;
            else                exp = EXP_IDLE;
            n_checks++;
            if (obs_fast !== exp) begin
                n_fail++;
                $display("FAIL hold1 cyc %0d: got %h expected %h", cyc, obs_fast, exp);
            end
            tick();
        end
        $display("test_hold1_last15 done");
    endtask

    task automatic test_pause;
        logic [11:0] exp;
        int code;
        logic stb;
        do_reset();
        start_pulse();
        for (int cyc = 1; cyc <= 59; cyc++) begin
            // code 0010 reaches hold_cnt=3 on cycle 24; pause spans seven edges
            pause = (cyc >= 24 && cyc <= 30);
            if (cyc <= 20)      code = (cyc - 1) / 10;
            else if (cyc <= 37) code = 2;
            else                code = 3 + (cyc - 38) / 10;
            stb = (cyc == 1 || cyc == 11 || cyc == 21 || cyc == 38 || cyc == 48);
            if (cyc <= 57)      exp = drv(code, stb);
            else if (cyc == 58) exp = EXP_DONE;
            else                exp = EXP_IDLE;
            n_checks++;
            if (obs_def !== exp) begin
                n_fail++;
                $display("FAIL pause cyc %0d: got %h expected %h", cyc, obs_def, exp);
            end
            tick();
        end
        pause = 1'b0;
        $display("test_pause done");
    endtask

    task automatic test_abort;
        do_reset();
        start_pulse();
        for (int cyc = 1; cyc < 33; cyc++) tick();
        n_checks++;
        if (obs_def !== drv(3, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_pre: got %h expected %h", obs_def, drv(3, 1'b0));
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_def !== EXP_IDLE) begin
                n_fail++;
                $display("FAIL abort_idle cyc %0d: got %h expected %h", i, obs_def, EXP_IDLE);
            end
            tick();
        end
        start_pulse();
        n_checks++;
        if (obs_def !== drv(0, 1'b1)) begin
            n_fail++;
            $display("FAIL abort_restart: got %h expected %h", obs_def, drv(0, 1'b1));
        end
        tick();
        n_checks++;
        if (obs_def !== drv(0, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_restart2: got %h expected %h", obs_def, drv(0, 1'b0));
        end
        $display("test_abort done");
    endtask

    task automatic test_async_reset;
        do_reset();
        start_pulse();
        for (int cyc = 1; cyc < 25; cyc++) tick();
        n_checks++;
        if (obs_def !== drv(2, 1'b0)) begin
            n_fail++;
            $display("FAIL areset_pre: got %h expected %h", obs_def, drv(2, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_def !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h expected %h", obs_def, EXP_IDLE);
        end
        tick();
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_def !== EXP_IDLE) begin
                n_fail++;
                $display("FAIL areset_release cyc %0d: got %h expected %h", i, obs_def, EXP_IDLE);
            end
            tick();
        end
        start_pulse();
        n_checks++;
        if (obs_def !== drv(0, 1'b1)) begin
            n_fail++;
            $display("FAIL areset_restart: got %h expected %h", obs_def, drv(0, 1'b1));
        end
        $display("test_async_reset done");
    endtask

    task automatic test_continuous;
        logic [11:0] exp;
        do_reset();
        start_pulse();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            exp = drv(((cyc - 1) / 2) % 2, ((cyc - 1) % 2) == 0);
            n_checks++;
            if (obs_cont !== exp) begin
                n_fail++;
                $display("FAIL continuous cyc %0d: got %h expected %h", cyc, obs_cont, exp);
            end
            if (cyc == 12) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_cont !== EXP_IDLE) begin
                n_fail++;
                $display("FAIL cont_abort cyc %0d: got %h expected %h", i, obs_cont, EXP_IDLE);
            end
            tick();
        end
        $display("test_continuous done");
    endtask

    initial begin
        test_reset();
        test_default();
        test_hold1_last15();
        test_pause();
        test_abort();
        test_async_reset();
        test_continuous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
